fb_write_arbiter: RTL

//  Sits directly downstream of the line-draw accelerator, in front of the single frame-buffer write port.

---
 rtl/fb_write_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// =============================================================================
// fb_write_arbiter: merges accelerator, clear-sweep and buffered CPU writes
// onto the single frame-buffer write port (priority XL > clear > CPU FIFO).
// Revision: 1.0
// =============================================================================
module fb_write_arbiter #(
  parameter int MEM_WIDTH      = 1,
  parameter int MEM_DEPTH      = 786432,
  parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      XL_wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0] XL_wr_addr,
  input  logic [MEM_WIDTH-1:0]      XL_wr_data,
  input  logic                      cpu_wr_valid,
  output logic                      cpu_wr_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [MEM_WIDTH-1:0]      cpu_wr_data,
  input  logic                      clr_start,
  input  logic [MEM_WIDTH-1:0]      clr_color,
  output logic                      clr_ready,
  output logic                      clr_busy,
  output logic                      fb_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [MEM_WIDTH-1:0]      fb_wr_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = MEM_ADDR_WIDTH'(1);
  localparam logic [PTR_W:0]            CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]            CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]          PTR_ONE   = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  logic [MEM_ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [MEM_WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wptr_q;
  logic [PTR_W-1:0]          rptr_q;
  logic [PTR_W:0]            count_q;
  logic [PTR_W:0]            count_d;

  state_e                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] clr_cnt_q;
  logic [MEM_WIDTH-1:0]      clr_color_q;

  logic                      fb_wr_en_q;
  logic [MEM_ADDR_WIDTH-1:0] fb_wr_addr_q;
  logic [MEM_WIDTH-1:0]      fb_wr_data_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic clr_grant;
  logic clr_accept;

  // All handshake outputs decode registered state only.
  assign fifo_full    = (count_q == CNT_FULL);
  assign fifo_empty   = (count_q == '0);
  assign clr_busy     = (state_q == ST_SWEEP);
  assign cpu_wr_ready = ~fifo_full;
  assign clr_ready    = ~clr_busy & fifo_empty;

  assign push       = cpu_wr_valid & ~fifo_full;
  assign clr_grant  = ~XL_wr_en & clr_busy;
  assign pop        = ~XL_wr_en & ~clr_busy & ~fifo_empty;
  assign clr_accept = clr_start & clr_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= cpu_wr_addr;
      fifo_data_q[wptr_q] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_accept) begin
            state_q     <= ST_SWEEP;
            clr_cnt_q   <= '0;
            clr_color_q <= clr_color;
          end
        end
        ST_SWEEP: begin
          // The counter only advances on cycles the clear actually owns the port.
          if (clr_grant) begin
            if (clr_cnt_q == LAST_ADDR) begin
              state_q   <= ST_IDLE;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + ADDR_ONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_wr_en_q   <= 1'b0;
      fb_wr_addr_q <= '0;
      fb_wr_data_q <= '0;
    end else begin
      fb_wr_en_q <= XL_wr_en | clr_busy | ~fifo_empty;
      if (XL_wr_en) begin
        fb_wr_addr_q <= XL_wr_addr;
        fb_wr_data_q <= XL_wr_data;
      end else if (clr_busy) begin
        fb_wr_addr_q <= clr_cnt_q;
        fb_wr_data_q <= clr_color_q;
      end else if (!fifo_empty) begin
        fb_wr_addr_q <= fifo_addr_q[rptr_q];
        fb_wr_data_q <= fifo_data_q[rptr_q];
      end
    end
  end

  assign fb_wr_en   = fb_wr_en_q;
  assign fb_wr_addr = fb_wr_addr_q;
  assign fb_wr_data = fb_wr_data_q;

endmodule
`default_nettype wire
